// File: rtl/pipe2_share_ctrl_pkg.sv
// Shared definitions for the pipe2_share_ctrl slice: FSM state encoding and symbol width.
package pipe2_share_ctrl_pkg;

    localparam int SYM_W = 2;

    // 2'd3 is not a legal state; the FSM falls back to ST_RUN if it ever appears.
    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_DRAIN   = 2'd1,
        ST_DRAINED = 2'd2
    } state_t;

endpackage

// File: rtl/pipe2_tag_shift.sv
// Shadow tag pipe: DEPTH stages of {valid,id} that track symbols travelling through the
// external pipe chain. Never stalls; synchronous active-low clear discards all tags.
module pipe2_tag_shift #(
    parameter int DEPTH = 4,
    parameter int IDW   = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           i_valid,
    input  logic [IDW-1:0] i_id,
    output logic           o_valid,
    output logic [IDW-1:0] o_id
);

    logic [DEPTH-1:0] r_vld;
    logic [IDW-1:0]   r_id [DEPTH];

    // Shift one stage per cycle; clear wipes every stage.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_vld <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_id[i] <= '0;
            end
        end else begin
            r_vld[0] <= i_valid;
            r_id[0]  <= i_id;
            for (int i = 1; i < DEPTH; i++) begin
                r_vld[i] <= r_vld[i-1];
                r_id[i]  <= r_id[i-1];
            end
        end
    end

    assign o_valid = r_vld[DEPTH-1];
    assign o_id    = r_id[DEPTH-1];

endmodule

// File: rtl/pipe2_share_ctrl.sv
// pipe2_share_ctrl: round-robin admission of 2-bit symbols from NREQ requesters into a shared
// external DEPTH-cycle pipe, with tagged output and a drain FSM for safe reconfiguration.
// Optional feature: define PIPE2_SHARE_STATS_EN to add per-requester saturating grant counters.
//
//  state      | meaning
//  -----------+-----------------------------------------------------------
//  ST_RUN     | arbitration active, one symbol admitted per cycle
//  ST_DRAIN   | admission stopped, waiting for in-flight symbols to exit
//  ST_DRAINED | pipe empty, drained=1, waiting for drain_req to drop
module pipe2_share_ctrl
    import pipe2_share_ctrl_pkg::*;
#(
    parameter int NREQ  = 2,
    parameter int DEPTH = 4,
    parameter int IDW   = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [SYM_W*NREQ-1:0]   req_data,
    output logic [NREQ-1:0]         req_ready,
    output logic [SYM_W-1:0]        pipe_ip,
    input  logic [SYM_W-1:0]        pipe_op,
    output logic                    out_valid,
    output logic [IDW-1:0]          out_id,
    output logic [SYM_W-1:0]        out_data,
    input  logic                    drain_req,
    output logic                    drained
`ifdef PIPE2_SHARE_STATS_EN
    ,
    output logic [16*NREQ-1:0]      grant_cnt
`endif
);

    localparam int CW = $clog2(DEPTH + 1);

    state_t          r_state;
    logic            r_drained;
    logic [IDW-1:0]  r_ptr;
    logic [CW-1:0]   r_inflight;

    logic            w_adm;
    logic            w_gnt_any;
    logic [IDW-1:0]  w_gnt_idx;
    logic [NREQ-1:0] w_gnt_oh;
    logic [SYM_W-1:0] w_pipe_ip;
    logic            w_out_valid;
    logic [IDW-1:0]  w_out_id;

    // Admission is only open in RUN and never while reset is asserted.
    assign w_adm = rst && (r_state == ST_RUN);

    // Round-robin search starting one past the last granted requester.
    always_comb begin
        logic [IDW-1:0] c;
        w_gnt_any = 1'b0;
        w_gnt_idx = '0;
        w_gnt_oh  = '0;
        w_pipe_ip = '0;
        c         = '0;
        for (int k = 1; k <= NREQ; k++) begin
            c = IDW'((int'(r_ptr) + k) % NREQ);
            if (!w_gnt_any && w_adm && req_valid[c]) begin
                w_gnt_any = 1'b1;
                w_gnt_idx = c;
            end
        end
        if (w_gnt_any) begin
            w_gnt_oh[w_gnt_idx] = 1'b1;
            w_pipe_ip           = req_data[SYM_W*w_gnt_idx +: SYM_W];
        end
    end

    assign req_ready = w_gnt_oh;
    assign pipe_ip   = w_pipe_ip;

    pipe2_tag_shift #(
        .DEPTH (DEPTH),
        .IDW   (IDW)
    ) u_tag (
        .clk     (clk),
        .rst     (rst),
        .i_valid (w_gnt_any),
        .i_id    (w_gnt_idx),
        .o_valid (w_out_valid),
        .o_id    (w_out_id)
    );

    assign out_valid = w_out_valid;
    assign out_id    = w_out_id;
    assign out_data  = pipe_op;
    assign drained   = r_drained;

    // Round-robin pointer and in-flight symbol count.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ptr      <= IDW'(NREQ - 1);
            r_inflight <= '0;
        end else begin
            if (w_gnt_any) begin
                r_ptr <= w_gnt_idx;
            end
            if (w_gnt_any && !w_out_valid) begin
                r_inflight <= r_inflight + CW'(1);
            end else if (!w_gnt_any && w_out_valid) begin
                r_inflight <= r_inflight - CW'(1);
            end
        end
    end

    // Drain FSM with registered drained flag.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= ST_RUN;
            r_drained <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    r_drained <= 1'b0;
                    if (drain_req) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    // The last symbol leaving this cycle counts as empty.
                    if ((r_inflight == '0) || ((r_inflight == CW'(1)) && w_out_valid)) begin
                        r_state   <= ST_DRAINED;
                        r_drained <= 1'b1;
                    end
                end
                ST_DRAINED: begin
                    if (!drain_req) begin
                        r_state   <= ST_RUN;
                        r_drained <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= ST_RUN;
                    r_drained <= 1'b0;
                end
            endcase
        end
    end

`ifdef PIPE2_SHARE_STATS_EN
    logic [15:0] r_grant_cnt [NREQ];

    // Per-requester saturating transfer counters.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NREQ; i++) begin
                r_grant_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (w_gnt_oh[i] && (r_grant_cnt[i] != 16'hFFFF)) begin
                    r_grant_cnt[i] <= r_grant_cnt[i] + 16'd1;
                end
            end
        end
    end

    always_comb begin
        grant_cnt = '0;
        for (int i = 0; i < NREQ; i++) begin
            grant_cnt[16*i +: 16] = r_grant_cnt[i];
        end
    end
`endif

endmodule

// File: tb/tb_pipe2_share_ctrl.sv
// Directed self-checking bench for pipe2_share_ctrl (NREQ=2, DEPTH=4).
// The external pipe is modelled as four 2-bit register stages.
module tb_pipe2_share_ctrl;

    logic       clk;
    logic       rst;
    logic [1:0] req_valid;
    logic [3:0] req_data;
    logic [1:0] req_ready;
    logic [1:0] pipe_ip;
    logic [1:0] pipe_op;
    logic       out_valid;
    logic [0:0] out_id;
    logic [1:0] out_data;
    logic       drain_req;
    logic       drained;
`ifdef PIPE2_SHARE_STATS_EN
    logic [31:0] grant_cnt;
`endif

    int total;
    int bad;

    logic [1:0] pq [4];

    pipe2_share_ctrl #(.NREQ(2), .DEPTH(4), .IDW(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .pipe_ip   (pipe_ip),
        .pipe_op   (pipe_op),
        .out_valid (out_valid),
        .out_id    (out_id),
        .out_data  (out_data),
        .drain_req (drain_req),
        .drained   (drained)
`ifdef PIPE2_SHARE_STATS_EN
        ,
        .grant_cnt (grant_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        pq[0] <= pipe_ip;
        pq[1] <= pq[0];
        pq[2] <= pq[1];
        pq[3] <= pq[2];
    end
    assign pipe_op = pq[3];

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b0;
        req_valid = 2'b00;
        req_data  = 4'b0000;
        drain_req = 1'b0;
        next_cycle();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst       = 1'b0;
        req_valid = 2'b11;
        req_data  = 4'b1001;
        drain_req = 1'b0;
        for (int c = 0; c < 2; c++) begin
            #2;
            total++;
            if (req_ready !== 2'b00) begin bad++; $display("FAIL reset_ready c=%0d got=%b exp=00", c, req_ready); end
            total++;
            if (pipe_ip !== 2'b00) begin bad++; $display("FAIL reset_pipe_ip c=%0d got=%b exp=00", c, pipe_ip); end
            total++;
            if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid c=%0d got=%b exp=0", c, out_valid); end
            total++;
            if (drained !== 1'b0) begin bad++; $display("FAIL reset_drained c=%0d got=%b exp=0", c, drained); end
            next_cycle();
        end
        rst = 1'b1;
        #2;
        total++;
        if (req_ready !== 2'b01) begin bad++; $display("FAIL reset_first_grant got=%b exp=01", req_ready); end
        total++;
        if (pipe_ip !== 2'd1) begin bad++; $display("FAIL reset_first_data got=%0d exp=1", pipe_ip); end
        next_cycle();
        req_valid = 2'b00;
    endtask

    task automatic test_alternate();
        logic [1:0] er;
        do_reset();
        req_valid = 2'b11;
        req_data  = 4'b1001;
        for (int c = 0; c < 12; c++) begin
            #2;
            er = (c % 2 == 0) ? 2'b01 : 2'b10;
            total++;
            if (req_ready !== er) begin bad++; $display("FAIL alt_ready c=%0d got=%b exp=%b", c, req_ready, er); end
            total++;
            if (pipe_ip !== ((c % 2 == 0) ? 2'd1 : 2'd2)) begin bad++; $display("FAIL alt_pipe_ip c=%0d got=%0d", c, pipe_ip); end
            total++;
            if (out_valid !== (c >= 4)) begin bad++; $display("FAIL alt_out_valid c=%0d got=%b exp=%b", c, out_valid, (c >= 4)); end
            if (c >= 4) begin
                total++;
                if (out_id !== 1'(c % 2)) begin bad++; $display("FAIL alt_out_id c=%0d got=%0d exp=%0d", c, out_id, c % 2); end
                total++;
                if (out_data !== ((c % 2 == 0) ? 2'd1 : 2'd2)) begin bad++; $display("FAIL alt_out_data c=%0d got=%0d", c, out_data); end
            end
            next_cycle();
        end
        req_valid = 2'b00;
    endtask

    task automatic test_single();
        do_reset();
        req_data = 4'b1100;
        for (int c = 0; c < 10; c++) begin
            req_valid = (c < 3) ? 2'b10 : 2'b00;
            #2;
            total++;
            if (req_ready !== ((c < 3) ? 2'b10 : 2'b00)) begin bad++; $display("FAIL single_ready c=%0d got=%b", c, req_ready); end
            total++;
            if (pipe_ip !== ((c < 3) ? 2'd3 : 2'd0)) begin bad++; $display("FAIL single_pipe_ip c=%0d got=%0d", c, pipe_ip); end
            total++;
            if (out_valid !== (c >= 4 && c < 7)) begin bad++; $display("FAIL single_out_valid c=%0d got=%b", c, out_valid); end
            if (c >= 4 && c < 7) begin
                total++;
                if (out_id !== 1'b1 || out_data !== 2'd3) begin bad++; $display("FAIL single_out c=%0d got id=%0d data=%0d exp id=1 data=3", c, out_id, out_data); end
            end
            next_cycle();
        end
    endtask

    task automatic test_drain();
        do_reset();
        req_valid = 2'b11;
        req_data  = 4'b1001;
        for (int c = 0; c < 14; c++) begin
            drain_req = (c >= 4 && c < 12);
            req_valid = 2'b11;
            #2;
            if (c == 4) begin
                total++;
                if (req_ready !== 2'b01) begin bad++; $display("FAIL drain_same_cycle_grant got=%b exp=01", req_ready); end
            end
            if (c >= 5 && c <= 12) begin
                total++;
                if (req_ready !== 2'b00) begin bad++; $display("FAIL drain_ready c=%0d got=%b exp=00", c, req_ready); end
            end
            if (c >= 4 && c <= 9) begin
                total++;
                if (out_valid !== (c <= 8)) begin bad++; $display("FAIL drain_out_valid c=%0d got=%b exp=%b", c, out_valid, (c <= 8)); end
            end
            if (c >= 4 && c <= 8) begin
                total++;
                if (out_id !== 1'(c % 2)) begin bad++; $display("FAIL drain_out_id c=%0d got=%0d exp=%0d", c, out_id, c % 2); end
            end
            if (c <= 13) begin
                total++;
                if (drained !== (c >= 9 && c <= 12)) begin bad++; $display("FAIL drain_drained c=%0d got=%b exp=%b", c, drained, (c >= 9 && c <= 12)); end
            end
            if (c == 13) begin
                total++;
                if (req_ready !== 2'b10) begin bad++; $display("FAIL drain_resume got=%b exp=10", req_ready); end
            end
            next_cycle();
        end
        req_valid = 2'b00;
        drain_req = 1'b0;
    endtask

    task automatic test_reset_midflight();
        do_reset();
        req_valid = 2'b11;
        req_data  = 4'b1001;
        for (int c = 0; c < 3; c++) next_cycle();
        rst = 1'b0;
        #2;
        total++;
        if (req_ready !== 2'b00 || pipe_ip !== 2'b00) begin bad++; $display("FAIL mid_reset_outputs got ready=%b ip=%b exp 00/00", req_ready, pipe_ip); end
        next_cycle();
        rst       = 1'b1;
        req_valid = 2'b00;
        #2;
        total++;
        if (dut.r_inflight !== 3'd0) begin bad++; $display("FAIL mid_inflight got=%0d exp=0", dut.r_inflight); end
        for (int c = 0; c < 6; c++) begin
            #2;
            total++;
            if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_out_valid c=%0d got=%b exp=0", c, out_valid); end
            next_cycle();
        end
        req_valid = 2'b11;
        #2;
        total++;
        if (req_ready !== 2'b01) begin bad++; $display("FAIL mid_next_grant got=%b exp=01", req_ready); end
        next_cycle();
        req_valid = 2'b00;
    endtask

`ifdef PIPE2_SHARE_STATS_EN
    task automatic test_stats();
        do_reset();
        req_data = 4'b1001;
        #2;
        total++;
        if (grant_cnt !== 32'd0) begin bad++; $display("FAIL stats_reset got=%h exp=0", grant_cnt); end
        next_cycle();
        req_valid = 2'b01;
        for (int c = 0; c < 5; c++) next_cycle();
        req_valid = 2'b10;
        for (int c = 0; c < 3; c++) next_cycle();
        req_valid = 2'b00;
        #2;
        total++;
        if (grant_cnt !== {16'd3, 16'd5}) begin bad++; $display("FAIL stats_count got=%h exp=00030005", grant_cnt); end
        force dut.r_grant_cnt[1] = 16'hFFFF;
        next_cycle();
        release dut.r_grant_cnt[1];
        req_valid = 2'b10;
        next_cycle();
        next_cycle();
        req_valid = 2'b00;
        #2;
        total++;
        if (grant_cnt[31:16] !== 16'hFFFF) begin bad++; $display("FAIL stats_saturate got=%h exp=ffff", grant_cnt[31:16]); end
        total++;
        if (grant_cnt[15:0] !== 16'd5) begin bad++; $display("FAIL stats_other got=%0d exp=5", grant_cnt[15:0]); end
        next_cycle();
    endtask
`endif

    initial begin
        total     = 0;
        bad       = 0;
        rst       = 1'b0;
        req_valid = 2'b00;
        req_data  = 4'b0000;
        drain_req = 1'b0;
        next_cycle();
        test_reset();
        test_alternate();
        test_single();
        test_drain();
        test_reset_midflight();
`ifdef PIPE2_SHARE_STATS_EN
        test_stats();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
